spi_nibble_queue: RTL and testbench
===================================

# spi_nibble_queue

Buffers the 4-bit words delivered by the SPI slave receiver. Each single-cycle valid pulse pushes one nibble into a parameterised first-word-fall-through FIFO. Downstream control logic drains the FIFO at its own pace, so a burst of SPI transfers is not lost while the consumer is busy. Overflow is reported through a sticky flag and, optionally, a drop counter.

## Interface
Parameters:
- DEPTH, 8, number of nibble entries; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override)

Ports:
- clk  in  1  system clock; same domain as the SPI slave receiver
- reset_n  in  1  asynchronous, active-low reset
- spi_data_in  in  4  nibble from the SPI receiver; sampled only when spi_data_valid_in=1
- spi_data_valid_in  in  1  single-cycle push strobe
- rd_en_in  in  1  pop request from the consumer
- flush_in  in  1  synchronous queue clear
- overflow_clr_in  in  1  clears the sticky overflow flag
- data_out  out  4  head entry; forced to 0 when the queue is empty
- data_valid_out  out  1  queue not empty
- full_out  out  1  count == DEPTH
- count_out  out  CW  current occupancy, 0..DEPTH
- overflow_out  out  1  sticky flag; set by a dropped push
- drop_count_out  out  8  saturating count of dropped pushes (present only with the macro)

## Operation
- Storage: DEPTH×4 register array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter cnt. All are log2(DEPTH) bits wide except cnt, which is CW bits. Pointers wrap modulo DEPTH.
- Push accepted: spi_data_valid_in & ~flush_in & (~full | pop).
  - Writes mem[wr_ptr].
  - Increments wr_ptr.
- Pop accepted: rd_en_in & data_valid_out & ~flush_in.
  - Increments rd_ptr.
  - rd_en_in while empty is ignored; there is no underflow state.
- cnt update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including at full and at empty.
- Full with simultaneous pop: both are accepted and cnt stays DEPTH. No overflow is flagged.
- Full without pop and spi_data_valid_in=1: the nibble is dropped. overflow_out is set on the next edge; drop_count increments and saturates at 255.
- Empty with simultaneous push and pop request: the push is accepted and the pop is ignored, because data_valid_out was 0. cnt becomes 1.
- flush_in=1:
  - Next edge sets wr_ptr=rd_ptr=cnt=0.
  - Any push that cycle is discarded and is not counted as overflow.
  - overflow_out and drop_count are unaffected.
- overflow_clr_in=1: clears overflow_out and drop_count. If a drop occurs in the same cycle, set wins: overflow_out=1 and drop_count=1.
- data_out = mem[rd_ptr] when cnt≠0, else 4'h0.
- Memory contents are not reset. They are never observable while empty because data_out is gated.

## Timing
- Reset (reset_n=0, asynchronous): every output is 0 (data_out, data_valid_out, full_out, count_out, overflow_out, drop_count_out). All pointers and counters are 0.
- Reset release is taken at the first clk edge with reset_n=1.
- Reset mid-operation clears the queue immediately, without waiting for a clock edge. Queued nibbles are lost.
- Push-to-visible latency: a nibble pushed at edge N into an empty queue appears on data_out with data_valid_out=1 after edge N, i.e. in cycle N+1.
- Pop: data_out advances to the next entry right after the popping edge. The consumer may pop on every cycle.
- full_out, count_out and data_valid_out are all derived from registered cnt, with no combinational path from the inputs.
- Pushes arrive at most once per SPI transfer, far slower than clk. The FIFO nevertheless must accept a push on every cycle.

## Configuration
- Macro: NIBBLE_QUEUE_DROP_COUNT_EN.
- Defined: drop_count_out port and its 8-bit saturating counter exist.
- Undefined: the port and the counter are absent. overflow_out behaviour is identical in both cases.

## Test plan
- Reset values: hold reset_n=0 with random inputs → all outputs 0. Assert reset_n=0 asynchronously mid-cycle with count_out=3 → count_out=0 and data_valid_out=0 before the next clk edge.
- In-order delivery (DEPTH=8): push 4'h1, 4'h2, 4'h3, then pop three times →
  - data_out sequence 1, 2, 3.
  - data_valid_out=1 from the cycle after the first push; it falls to 0 after the third pop.
- Overflow: push 9 nibbles 4'h0..4'h8 with no pop →
  - full_out=1 after the 8th push.
  - 9th push is dropped: overflow_out=1, drop_count_out=1.
  - Draining yields 0..7.
  - overflow_clr_in → overflow_out=0, drop_count_out=0.
- Simultaneous events at the boundaries:
  - At full: push 4'hA together with pop → count_out stays 8, overflow_out stays 0, and 4'hA is the last entry drained.
  - At empty: push together with rd_en_in → count_out=1.
  - Drop together with overflow_clr_in → overflow_out=1.
- Wrap-around: run 20 interleaved push/pop pairs with occupancy 1..3 → no data loss, order preserved, pointers wrap cleanly.
- Flush: flush_in with count_out=5 and a coincident push → count_out=0, data_out=0, overflow_out unchanged, and a subsequent push of 4'h7 is read back as 4'h7.

Source files
------------

// File: rtl/spi_nibble_queue_if.sv
// Nibble queue bus: SPI push side, consumer pop side, status. Carries
// drop_count_out only when NIBBLE_QUEUE_DROP_COUNT_EN is defined.
interface spi_nibble_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    spi_data_in;
  logic          spi_data_valid_in;
  logic          rd_en_in;
  logic          flush_in;
  logic          overflow_clr_in;
  logic [3:0]    data_out;
  logic          data_valid_out;
  logic          full_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
  logic [7:0]    drop_count_out;
`endif

  modport master (
    output spi_data_in, spi_data_valid_in, rd_en_in, flush_in, overflow_clr_in,
    input  data_out, data_valid_out, full_out, count_out, overflow_out
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
    , input drop_count_out
`endif
  );

  modport slave (
    input  spi_data_in, spi_data_valid_in, rd_en_in, flush_in, overflow_clr_in,
    output data_out, data_valid_out, full_out, count_out, overflow_out
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
    , output drop_count_out
`endif
  );
endinterface

// File: rtl/spi_nibble_queue.sv
// FWFT nibble FIFO behind the SPI receiver; push visible the cycle after its edge, pop every cycle.
// Pushes at full without a pop are dropped and flagged (sticky overflow, drop counter under NIBBLE_QUEUE_DROP_COUNT_EN).
module spi_nibble_queue #(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             reset_n,
  spi_nibble_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic not_empty, full, push, pop, drop;

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  // A pop at full frees the slot the same edge, so that push is not a drop.
  assign pop       = q.rd_en_in & not_empty & ~q.flush_in;
  assign push      = q.spi_data_valid_in & ~q.flush_in & (~full | pop);
  assign drop      = q.spi_data_valid_in & ~q.flush_in & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (q.flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = q.spi_data_in;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  // A drop wins over a coincident clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (q.overflow_clr_in) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (q.overflow_clr_in)          drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)   drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (q.overflow_clr_in) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign q.drop_count_out = drop_cnt_q;
`endif

  assign q.data_out       = not_empty ? mem_q[rd_ptr_q] : 4'h0;
  assign q.data_valid_out = not_empty;
  assign q.full_out       = full;
  assign q.count_out      = cnt_q;
  assign q.overflow_out   = ovf_q;
endmodule

// File: tb/tb_spi_nibble_queue.sv
// Bench for spi_nibble_queue: vector table, directed boundary sequences, then
// randomized traffic against a queue-based reference model.
module tb_spi_nibble_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_nibble_queue_if #(.DEPTH(DEPTH)) q_if ();
  spi_nibble_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .q(q_if));

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a plain queue, plus sticky flag and drop count.
  logic [3:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_dc  = 0;

  typedef struct {
    bit         vld;
    logic [3:0] d;
    bit         rd;
    int         e_cnt;
    int         e_dat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit vld, input logic [3:0] d, input bit rd,
                            input bit fl, input bit clr);
    bit do_pop, do_push, do_drop;
    if (fl) begin
      mq.delete();
      do_drop = 1'b0;
    end else begin
      do_pop  = rd && (mq.size() > 0);
      do_push = vld && ((mq.size() < DEPTH) || do_pop);
      do_drop = vld && !do_push;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
    if (do_drop) begin
      m_ovf = 1'b1;
      m_dc  = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
  endtask

  task automatic apply(input bit vld, input logic [3:0] d, input bit rd,
                       input bit fl, input bit clr);
    q_if.spi_data_valid_in = vld;
    q_if.spi_data_in       = d;
    q_if.rd_en_in          = rd;
    q_if.flush_in          = fl;
    q_if.overflow_clr_in   = clr;
    model_step(vld, d, rd, fl, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count"}, 32'(q_if.count_out), 32'(mq.size()));
    chk({tag, " valid"}, 32'(q_if.data_valid_out), 32'(mq.size() > 0));
    chk({tag, " full"},  32'(q_if.full_out), 32'(mq.size() == DEPTH));
    chk({tag, " data"},  32'(q_if.data_out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, " ovf"},   32'(q_if.overflow_out), 32'(m_ovf));
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
    chk({tag, " dcnt"},  32'(q_if.drop_count_out), 32'(m_dc));
`endif
  endtask

  task automatic fill8();
    for (int k = 0; k < DEPTH; k++) apply(1'b1, 4'(k), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'h1, 1'b0, 1, 1};
    tbl[1] = '{1'b1, 4'h2, 1'b0, 2, 1};
    tbl[2] = '{1'b1, 4'h3, 1'b0, 3, 1};
    tbl[3] = '{1'b0, 4'h0, 1'b1, 2, 2};
    tbl[4] = '{1'b0, 4'h0, 1'b1, 1, 3};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 0, 0};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 0, 0};
    tbl[7] = '{1'b1, 4'h5, 1'b1, 1, 5};
    tbl[8] = '{1'b1, 4'h9, 1'b1, 1, 9};
    tbl[9] = '{1'b0, 4'h0, 1'b1, 0, 0};

    // Reset held with random inputs: every output must read zero.
    for (int i = 0; i < 4; i++) begin
      q_if.spi_data_valid_in = 1'($urandom);
      q_if.spi_data_in       = 4'($urandom);
      q_if.rd_en_in          = 1'($urandom);
      q_if.flush_in          = 1'($urandom);
      q_if.overflow_clr_in   = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst count", 32'(q_if.count_out), 32'd0);
      chk("rst valid", 32'(q_if.data_valid_out), 32'd0);
      chk("rst full",  32'(q_if.full_out), 32'd0);
      chk("rst data",  32'(q_if.data_out), 32'd0);
      chk("rst ovf",   32'(q_if.overflow_out), 32'd0);
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
      chk("rst dcnt",  32'(q_if.drop_count_out), 32'd0);
`endif
    end
    q_if.spi_data_valid_in = 1'b0;
    q_if.spi_data_in       = 4'h0;
    q_if.rd_en_in          = 1'b0;
    q_if.flush_in          = 1'b0;
    q_if.overflow_clr_in   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // In-order delivery, pop on empty, push with pop request on empty.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].vld, tbl[i].d, tbl[i].rd, 1'b0, 1'b0);
      chk($sformatf("vec%0d count", i), 32'(q_if.count_out), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d data", i),  32'(q_if.data_out), 32'(tbl[i].e_dat));
      chk($sformatf("vec%0d valid", i), 32'(q_if.data_valid_out), 32'(tbl[i].e_cnt != 0));
    end

    // Overflow: 9 pushes, 9th dropped, drain 0..7, then clear.
    fill8();
    chk("ovfl full", 32'(q_if.full_out), 32'd1);
    chk("ovfl ovf_before", 32'(q_if.overflow_out), 32'd0);
    apply(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    chk("ovfl count", 32'(q_if.count_out), 32'd8);
    chk("ovfl ovf", 32'(q_if.overflow_out), 32'd1);
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
    chk("ovfl dcnt", 32'(q_if.drop_count_out), 32'd1);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      chk("ovfl drain", 32'(q_if.data_out), 32'(k));
      apply(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("ovfl empty", 32'(q_if.data_valid_out), 32'd0);
    apply(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("ovfl clr", 32'(q_if.overflow_out), 32'd0);
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
    chk("ovfl clr dcnt", 32'(q_if.drop_count_out), 32'd0);
`endif

    // Push together with pop at full: accepted, no overflow, A drains last.
    fill8();
    apply(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    chk("fullpp count", 32'(q_if.count_out), 32'd8);
    chk("fullpp ovf", 32'(q_if.overflow_out), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      chk("fullpp drain", 32'(q_if.data_out), (k < 7) ? 32'(k + 1) : 32'hA);
      apply(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    end

    // Two drops, then a drop coinciding with clear: set wins.
    fill8();
    apply(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    chk("dropclr ovf", 32'(q_if.overflow_out), 32'd1);
`ifdef NIBBLE_QUEUE_DROP_COUNT_EN
    chk("dropclr dcnt", 32'(q_if.drop_count_out), 32'd1);
`endif
    check_all("dropclr");

    // Flush at count 5 with a coincident push.
    apply(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) apply(1'b1, 4'(k + 3), 1'b0, 1'b0, 1'b0);
    chk("flush pre count", 32'(q_if.count_out), 32'd5);
    apply(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    chk("flush count", 32'(q_if.count_out), 32'd0);
    chk("flush data", 32'(q_if.data_out), 32'd0);
    chk("flush ovf", 32'(q_if.overflow_out), 32'd1);
    apply(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    chk("flush push7", 32'(q_if.data_out), 32'h7);
    check_all("flush");

    // Asynchronous reset mid-cycle with three entries queued.
    apply(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
    chk("arst pre count", 32'(q_if.count_out), 32'd3);
    q_if.spi_data_valid_in = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst count", 32'(q_if.count_out), 32'd0);
    chk("arst valid", 32'(q_if.data_valid_out), 32'd0);
    chk("arst ovf",   32'(q_if.overflow_out), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    m_dc  = 0;
    #2;
    reset_n = 1'b1;

    // Wrap-around: occupancy cycles 1..3 for many pointer laps.
    apply(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
      check_all("wrap");
      apply(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
      check_all("wrap");
      apply(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      check_all("wrap");
      apply(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      check_all("wrap");
    end

    // Randomized traffic, alternating light and heavy consumer phases.
    for (int i = 0; i < 1600; i++) begin
      int rd_pct;
      rd_pct = ((i / 200) % 2 == 1) ? 70 : 20;
      apply($urandom_range(0, 99) < 55, 4'($urandom),
            $urandom_range(0, 99) < rd_pct,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 4);
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
